// File: rtl/frame_cfg_pkg.sv
// Shared definitions for the frame configuration loader: header layout and FSM states.
package frame_cfg_pkg;

  localparam logic [3:0] HDR_MARKER = 4'hA;
  localparam int HDR_MRK_LO = 28;
  localparam int HDR_COL_LO = 20;
  localparam int HDR_FRM_LO = 15;
  localparam int COL_W      = 8;
  localparam int FRM_W      = 5;

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, STROBE, HOLD} state_e;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered one-hot decode of (column, frame, fire) into the FrameStrobe vector.
module frame_strobe_decoder
  import frame_cfg_pkg::*;
#(
  parameter int NumCols         = 16,
  parameter int MaxFramesPerCol = 20
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                fire_i,
  input  logic [COL_W-1:0]                    col_i,
  input  logic [FRM_W-1:0]                    frm_i,
  output logic [NumCols*MaxFramesPerCol-1:0]  strobe_o
);

  logic [NumCols*MaxFramesPerCol-1:0] strobe_d, strobe_q;

  for (genvar c = 0; c < NumCols; c++) begin : g_col
    for (genvar f = 0; f < MaxFramesPerCol; f++) begin : g_frm
      assign strobe_d[c*MaxFramesPerCol+f] = fire_i && (col_i == COL_W'(c)) && (frm_i == FRM_W'(f));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) strobe_q <= '0;
    else       strobe_q <= strobe_d;
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/frame_config_loader.sv
// Parses a header/data word stream and loads one frame into the row FrameData registers,
// then fires a single FrameStrobe bit. Optional frame parity check: CONFIG_PARITY_EN.
module frame_config_loader
  import frame_cfg_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumRows         = 16,
  parameter int NumCols         = 16
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [31:0]                         s_data,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic                                err_clr,
  output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
  output logic [NumCols*MaxFramesPerCol-1:0]  FrameStrobe,
  output logic                                busy,
  output logic                                err,
  output logic [15:0]                         frame_count
);

  localparam int ROW_W = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NumRows - 1);

  state_e                                   state_q, state_d;
  logic [ROW_W-1:0]                         row_q, row_d;
  logic [COL_W-1:0]                         col_q;
  logic [FRM_W-1:0]                         frm_q;
  logic [NumRows-1:0][FrameBitsPerRow-1:0]  frame_data_q;
  logic                                     s_ready_q, busy_q, err_q, err_d;
  logic [15:0]                              frame_count_q;

  logic             xfer, hdr_ok, hdr_take, row_wr, fire, bad_hdr, par_err;
  logic [COL_W-1:0] hdr_col;
  logic [FRM_W-1:0] hdr_frm;

  assign xfer    = s_valid && s_ready_q;
  assign hdr_col = s_data[HDR_COL_LO +: COL_W];
  assign hdr_frm = s_data[HDR_FRM_LO +: FRM_W];
  assign hdr_ok  = (s_data[HDR_MRK_LO +: 4] == HDR_MARKER) &&
                   (int'(hdr_col) < NumCols) && (int'(hdr_frm) < MaxFramesPerCol);

`ifdef CONFIG_PARITY_EN
  logic [31:0] par_q;

  // Running XOR of the rows of the frame being loaded.
  always_ff @(posedge CLK) begin
    if (RST)           par_q <= '0;
    else if (hdr_take) par_q <= '0;
    else if (row_wr)   par_q <= par_q ^ s_data;
  end
`endif

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    hdr_take = 1'b0;
    row_wr   = 1'b0;
    fire     = 1'b0;
    bad_hdr  = 1'b0;
    par_err  = 1'b0;
    case (state_q)
      IDLE: if (xfer) begin
        if (hdr_ok) begin
          state_d  = LOAD;
          row_d    = '0;
          hdr_take = 1'b1;
        end else begin
          bad_hdr  = 1'b1;
        end
      end
      LOAD: if (xfer) begin
        row_wr = 1'b1;
        row_d  = row_q + 1'b1;
        if (row_q == LAST_ROW) begin
`ifdef CONFIG_PARITY_EN
          state_d = CHECK;
`else
          state_d = STROBE;
          fire    = 1'b1;
`endif
        end
      end
`ifdef CONFIG_PARITY_EN
      CHECK: if (xfer) begin
        if (s_data == par_q) begin
          state_d = STROBE;
          fire    = 1'b1;
        end else begin
          state_d = HOLD;
          par_err = 1'b1;
        end
      end
`endif
      STROBE:  state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new error in the same cycle as err_clr wins.
  always_comb begin
    err_d = err_q;
    if (err_clr)           err_d = 1'b0;
    if (bad_hdr || par_err) err_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      row_q         <= '0;
      col_q         <= '0;
      frm_q         <= '0;
      frame_data_q  <= '0;
      s_ready_q     <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      s_ready_q <= (state_d == IDLE) || (state_d == LOAD) || (state_d == CHECK);
      busy_q    <= (state_d != IDLE);
      err_q     <= err_d;
      if (hdr_take) begin
        col_q <= hdr_col;
        frm_q <= hdr_frm;
      end
      if (row_wr) frame_data_q[row_q] <= s_data;
      if (fire)   frame_count_q <= frame_count_q + 16'd1;
    end
  end

  frame_strobe_decoder #(
    .NumCols         (NumCols),
    .MaxFramesPerCol (MaxFramesPerCol)
  ) u_dec (
    .clk_i    (CLK),
    .rst_i    (RST),
    .fire_i   (fire),
    .col_i    (col_q),
    .frm_i    (frm_q),
    .strobe_o (FrameStrobe)
  );

  assign FrameData   = frame_data_q;
  assign s_ready     = s_ready_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_config_loader.sv
// Directed bench for frame_config_loader with NumRows=2, NumCols=4 (80 strobe bits).
module tb_frame_config_loader;

  logic        CLK = 1'b0;
  logic        RST, s_valid, s_ready, err_clr, busy, err;
  logic [31:0] s_data;
  logic [63:0] FrameData;
  logic [79:0] FrameStrobe;
  logic [15:0] frame_count;

  int total  = 0;
  int passed = 0;

  frame_config_loader #(
    .FrameBitsPerRow (32),
    .MaxFramesPerCol (20),
    .NumRows         (2),
    .NumCols         (4)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .err_clr     (err_clr),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .err         (err),
    .frame_count (frame_count)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [79:0] sb(input int idx);
    logic [79:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  logic [31:0] bw[10] = '{32'hA019_8000, 32'hAAAA_0001, 32'hAAAA_0002, 32'hA022_8000, 32'hA022_8000,
                          32'hA022_8000, 32'hBBBB_0001, 32'hBBBB_0002, 32'h0, 32'h0};
  bit          bv[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  bit          er[10] = '{1, 1, 0, 0, 1, 1, 1, 0, 0, 1};
  int          es[10] = '{-1, -1, 39, -1, -1, -1, -1, 45, -1, -1};

  initial begin
    RST = 1'b1; s_valid = 1'b0; s_data = '0; err_clr = 1'b0;
    step();
    chk("rst_ready",  s_ready,     0);
    chk("rst_data",   FrameData,   0);
    chk("rst_strobe", FrameStrobe, 0);
    chk("rst_busy",   busy,        0);
    chk("rst_err",    err,         0);
    chk("rst_count",  frame_count, 0);
    RST = 1'b0;
    step();
    chk("post_rst_ready", s_ready, 1);

    // Bad column, then clear.
    s_data = 32'hA050_0000; s_valid = 1'b1;
    step();
    chk("badcol_err",    err,         1);
    chk("badcol_ready",  s_ready,     1);
    chk("badcol_busy",   busy,        0);
    chk("badcol_strobe", FrameStrobe, 0);
    s_valid = 1'b0; err_clr = 1'b1;
    step();
    chk("errclr", err, 0);
    err_clr = 1'b0;
    s_data = 32'hB030_0000; s_valid = 1'b1;
    step();
    chk("badmrk_err", err, 1);
    s_data = 32'hA00A_0000; err_clr = 1'b1;
    step();
    chk("badfrm_clr_same_cycle", err, 1);
    s_valid = 1'b0;
    step();
    chk("errclr2", err, 0);
    err_clr = 1'b0;

    // Reset in the middle of a load.
    s_data = 32'hA020_0000; s_valid = 1'b1;
    step();
    s_data = 32'h5555_5555;
    step();
    chk("midrst_row0", FrameData, 64'h0000_0000_5555_5555);
    RST = 1'b1; s_data = 32'h6666_6666;
    step();
    chk("midrst_busy",   busy,        0);
    chk("midrst_data",   FrameData,   0);
    chk("midrst_strobe", FrameStrobe, 0);
    chk("midrst_ready",  s_ready,     0);
    RST = 1'b0; s_valid = 1'b0;
    step();
    chk("midrst_idle_ready",  s_ready,     1);
    chk("midrst_idle_strobe", FrameStrobe, 0);

`ifdef CONFIG_PARITY_EN
    s_data = 32'hA030_0000; s_valid = 1'b1;
    step();
    s_data = 32'h0F0F_0F0F;
    step();
    s_data = 32'hFFFF_0000;
    step();
    chk("chk_ready",  s_ready,     1);
    chk("chk_busy",   busy,        1);
    chk("chk_strobe", FrameStrobe, 0);
    s_data = 32'hF0F0_0F0F;
    step();
    chk("par_ok_strobe", FrameStrobe, sb(60));
    chk("par_ok_count",  frame_count, 1);
    s_valid = 1'b0;
    step();
    step();
    chk("par_ok_idle", s_ready, 1);
    s_data = 32'hA030_0000; s_valid = 1'b1;
    step();
    s_data = 32'h0F0F_0F0F;
    step();
    s_data = 32'hFFFF_0000;
    step();
    s_data = 32'h0;
    step();
    chk("par_bad_err",    err,         1);
    chk("par_bad_strobe", FrameStrobe, 0);
    chk("par_bad_count",  frame_count, 1);
    chk("par_bad_ready",  s_ready,     0);
    s_valid = 1'b0;
    step();
    chk("par_bad_idle",   s_ready,     1);
    chk("par_bad_strobe2", FrameStrobe, 0);
`else
    // Basic frame: column 3, frame 0.
    s_data = 32'hA030_0000; s_valid = 1'b1;
    step();
    chk("f1_busy", busy, 1);
    s_data = 32'h1111_1111;
    step();
    s_data = 32'h2222_2222;
    step();
    chk("f1_strobe", FrameStrobe, sb(60));
    chk("f1_data",   FrameData,   64'h2222_2222_1111_1111);
    chk("f1_count",  frame_count, 1);
    chk("f1_ready",  s_ready,     0);
    s_valid = 1'b0;
    step();
    chk("f1_hold_strobe", FrameStrobe, 0);
    chk("f1_hold_ready",  s_ready,     0);
    step();
    chk("f1_idle_ready", s_ready, 1);
    chk("f1_idle_busy",  busy,    0);

    // Back-to-back frames at full valid.
    for (int k = 0; k < 10; k++) begin
      s_data = bw[k]; s_valid = bv[k];
      step();
      chk($sformatf("b2b_ready_%0d", k),  s_ready,     er[k]);
      chk($sformatf("b2b_strobe_%0d", k), FrameStrobe, sb(es[k]));
    end
    chk("b2b_data",  FrameData,   64'hBBBB_0002_BBBB_0001);
    chk("b2b_count", frame_count, 3);

    // Stall between data words.
    s_data = 32'hA000_8000; s_valid = 1'b1;
    step();
    s_data = 32'h1234_5678;
    step();
    s_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("stall_strobe_%0d", k), FrameStrobe, 0);
    end
    chk("stall_busy",  busy,    1);
    chk("stall_ready", s_ready, 1);
    s_data = 32'h9ABC_DEF0; s_valid = 1'b1;
    step();
    chk("stall_fire",  FrameStrobe, sb(1));
    chk("stall_data",  FrameData,   64'h9ABC_DEF0_1234_5678);
    chk("stall_count", frame_count, 4);
    s_valid = 1'b0;
    step();
    step();
    chk("stall_idle", s_ready, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
